uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning byte width of both streams.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning storage entries; legal values are powers of two, 2..256.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-2, meaning the level at or above which almost_full_o asserts.
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port s_axis_tdata_i, input, DATA_W bits: byte from the producer (host logic).
REQ-007 The block SHALL have port s_axis_tvalid_i, input, 1 bit: producer byte valid.
REQ-008 The block SHALL have port s_axis_tready_o, output, 1 bit: FIFO accepts a byte this cycle.
REQ-009 The block SHALL have port m_axis_tdata_o, output, DATA_W bits: head byte to the UART transmitter slave stream.
REQ-010 The block SHALL have port m_axis_tvalid_o, output, 1 bit: head byte valid.
REQ-011 The block SHALL have port m_axis_tready_i, input, 1 bit: UART transmitter takes head byte.
REQ-012 The block SHALL have port level_o, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-013 The block SHALL have port almost_full_o, output, 1 bit: level_o >= AFULL_TH.
REQ-014 The block SHALL have port overflow_o, output, 1 bit: sticky flag, producer offered a byte while full.

Function
REQ-015 Push SHALL occur when s_axis_tvalid_i && s_axis_tready_o at a rising edge; pop SHALL occur when m_axis_tvalid_o && m_axis_tready_i.
REQ-016 s_axis_tready_o SHALL be a registered output equal to (level != DEPTH) after each edge; no combinational path from m_axis_tready_i.
REQ-017 Full with simultaneous pop: tready SHALL stay 0 that cycle (no push), then rise the next cycle.
REQ-018 m_axis_tvalid_o SHALL be registered; first-word-fall-through: a byte pushed into an empty FIFO at edge N SHALL appear with tvalid=1 after edge N; latency one cycle.
REQ-019 m_axis_tdata_o SHALL hold stable while m_axis_tvalid_o=1 and m_axis_tready_i=0 (AXI-stream rule).
REQ-020 Once asserted, m_axis_tvalid_o SHALL NOT drop until the byte is popped.
REQ-021 Bytes SHALL leave in exact arrival order; no drop, no duplication.
REQ-022 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH silently; full/empty SHALL derive from the level counter.
REQ-023 Simultaneous push and pop with 0<level<DEPTH: level SHALL be unchanged, both pointers advance.
REQ-024 Empty with push and no valid head: push only, level becomes 1.
REQ-025 overflow_o SHALL set on any edge where s_axis_tvalid_i=1 and s_axis_tready_o=0, and clears only by reset; the offered byte is not stored.
REQ-026 level_o and almost_full_o SHALL be registered and reflect occupancy after each edge, including the output holding register.

Reset
REQ-027 While rst_ni=0: s_axis_tready_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, level_o=0, almost_full_o=0, overflow_o=0, pointers=0.
REQ-028 Reset SHALL take effect asynchronously, mid-transfer included; stored bytes are discarded.
REQ-029 s_axis_tready_o SHALL rise at the first rising edge after rst_ni deasserts; storage array needs no reset.

Verification
REQ-030 Reset release, idle: -> tready=1 after first edge, tvalid=0, level=0, overflow=0.
REQ-031 Push 0x41 into empty FIFO, m_axis_tready_i=0 -> next cycle tvalid=1, tdata=0x41, level=1; holds 0x41 for 10 stalled cycles.
REQ-032 DEPTH=16, push 0x00..0x0F with sink stalled -> level=16, tready=0, almost_full=1 from level 14; extra offer 0xAA -> overflow=1, 0xAA never emitted.
REQ-033 From full, pop one and offer 0x55 same cycle -> no push that cycle, level=15; 0x55 accepted next cycle, level=16.
REQ-034 Random valid/ready (50%), 1000 bytes through DEPTH=4 with wraps -> output sequence equals input sequence, level never exceeds 4.
REQ-035 rst_ni pulled low with level=7 -> outputs immediately at reset values; after release level=0, no stale byte emitted.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between host logic and a UART transmitter.
// First-word-fall-through head register; every output is registered.
module uart_tx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_W-1:0]       s_axis_tdata_i,
    input  logic                    s_axis_tvalid_i,
    output logic                    s_axis_tready_o,
    output logic [DATA_W-1:0]       m_axis_tdata_o,
    output logic                    m_axis_tvalid_o,
    input  logic                    m_axis_tready_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    almost_full_o,
    output logic                    overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_tready;
    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;
    logic              r_afull;
    logic              r_ovf;

    logic              w_push;
    logic              w_pop;
    logic              w_bypass;
    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [LW-1:0]     w_level_nxt;
    logic [DATA_W-1:0] w_tdata_nxt;

    always_comb begin
        w_push       = s_axis_tvalid_i && r_tready;
        w_pop        = r_tvalid && m_axis_tready_i;
        w_wr_ptr_nxt = r_wr_ptr + AW'(w_push);
        w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
        w_level_nxt  = r_level + LW'(w_push) - LW'(w_pop);
        // Next head is the byte being written this very edge
        w_bypass     = w_push && (r_wr_ptr == w_rd_ptr_nxt);
        w_tdata_nxt  = '0;
        if (w_level_nxt != '0) begin
            if (w_bypass) begin
                w_tdata_nxt = s_axis_tdata_i;
            end else begin
                w_tdata_nxt = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_tdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_tready <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_tready <= (w_level_nxt != LW'(DEPTH));
            r_tvalid <= (w_level_nxt != '0);
            r_tdata  <= w_tdata_nxt;
            r_afull  <= (w_level_nxt >= LW'(AFULL_TH));
            if (s_axis_tvalid_i && !r_tready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign s_axis_tready_o = r_tready;
    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tdata_o  = r_tdata;
    assign level_o         = r_level;
    assign almost_full_o   = r_afull;
    assign overflow_o      = r_ovf;

endmodule
